decode_pipe: RTL

//  Y86-64 decode/register-read stage. Consumes the D_* pipeline register written by fetch_pipe
//  and owns the 15x64 register file, whose write port is driven by writeback.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/y86_regfile.sv | 35 +++
 rtl/decode_pipe.sv | 106 ++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 opcodes, register indices, status codes and the E pipeline register layout.
package y86_pkg;
  localparam int XLEN = 64;
  localparam int NREGS = 15;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [3:0] RNONE = 4'hF, RSP = 4'h4;
  localparam logic [1:0] STAT_AOK = 2'b00, STAT_HLT = 2'b01, STAT_ADR = 2'b10, STAT_INS = 2'b11;
  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [1:0]      stat;
    logic [XLEN-1:0] val_c;
    logic [XLEN-1:0] val_a;
    logic [XLEN-1:0] val_b;
    logic [3:0]      dst_e;
    logic [3:0]      dst_m;
    logic [3:0]      src_a;
    logic [3:0]      src_b;
  } e_reg_t;
  localparam e_reg_t E_BUBBLE = '{icode: I_NOP, ifun: 4'h0, stat: STAT_AOK, val_c: '0, val_a: '0,
                                  val_b: '0, dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE};
endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: 15x64 register file, two async reads, two sync writes (M beats E on collision).
// DECODE_REG_DUMP_EN adds a combinational debug read port dbg_sel/dbg_val.
module y86_regfile
  import y86_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
`ifdef DECODE_REG_DUMP_EN
  input  logic [3:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_val,
`endif
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] val_e,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] val_m,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b
);
  logic [XLEN-1:0] regs_q [NREGS];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (dst_e != RNONE) regs_q[dst_e] <= val_e;
      if (dst_m != RNONE) regs_q[dst_m] <= val_m;
    end
  end
  assign rd_a = (src_a == RNONE) ? '0 : regs_q[src_a];
  assign rd_b = (src_b == RNONE) ? '0 : regs_q[src_b];
`ifdef DECODE_REG_DUMP_EN
  assign dbg_val = (dbg_sel == RNONE) ? '0 : regs_q[dbg_sel];
`endif
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: Y86-64 decode/register-read stage with e/M/W forwarding and the E pipeline register.
// DECODE_REG_DUMP_EN exposes a debug register read port (dbg_sel/dbg_val).
module decode_pipe
  import y86_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
`ifdef DECODE_REG_DUMP_EN
  input  logic [3:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_val,
`endif
  input  logic [3:0]      D_in_code,
  input  logic [3:0]      D_in_fun,
  input  logic [3:0]      D_ra,
  input  logic [3:0]      D_rb,
  input  logic [XLEN-1:0] D_val_c,
  input  logic [XLEN-1:0] D_val_p,
  input  logic [1:0]      D_stat,
  input  logic            E_bub,
  input  logic [3:0]      e_dst_e,
  input  logic [XLEN-1:0] e_val_e,
  input  logic [3:0]      M_dst_m,
  input  logic [XLEN-1:0] m_val_m,
  input  logic [3:0]      M_dst_e,
  input  logic [XLEN-1:0] M_val_e,
  input  logic [3:0]      W_dst_m,
  input  logic [XLEN-1:0] W_val_m,
  input  logic [3:0]      W_dst_e,
  input  logic [XLEN-1:0] W_val_e,
  output logic [3:0]      d_src_a,
  output logic [3:0]      d_src_b,
  output logic [3:0]      E_in_code,
  output logic [3:0]      E_in_fun,
  output logic [1:0]      E_stat,
  output logic [XLEN-1:0] E_val_c,
  output logic [XLEN-1:0] E_val_a,
  output logic [XLEN-1:0] E_val_b,
  output logic [3:0]      E_dst_e,
  output logic [3:0]      E_dst_m,
  output logic [3:0]      E_src_a,
  output logic [3:0]      E_src_b
);
  e_reg_t e_q, e_d;
  logic [3:0] dst_e, dst_m;
  logic [XLEN-1:0] rd_a, rd_b;
  function automatic logic [XLEN-1:0] fwd(input logic [3:0] src, input logic [XLEN-1:0] rf);
    return (src == RNONE) ? '0 :
           (src == e_dst_e) ? e_val_e :
           (src == M_dst_m) ? m_val_m :
           (src == M_dst_e) ? M_val_e :
           (src == W_dst_m) ? W_val_m :
           (src == W_dst_e) ? W_val_e : rf;
  endfunction
  assign d_src_a = (D_in_code inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) ? D_ra :
                   (D_in_code inside {I_RET, I_POPQ}) ? RSP : RNONE;
  assign d_src_b = (D_in_code inside {I_RMMOVQ, I_MRMOVQ, I_OPQ}) ? D_rb :
                   (D_in_code inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP : RNONE;
  assign dst_e = (D_in_code inside {I_RRMOVQ, I_IRMOVQ, I_OPQ}) ? D_rb :
                 (D_in_code inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP : RNONE;
  assign dst_m = (D_in_code inside {I_MRMOVQ, I_POPQ}) ? D_ra : RNONE;
  y86_regfile u_rf (
    .clock  (clock),
    .reset_n(reset_n),
`ifdef DECODE_REG_DUMP_EN
    .dbg_sel(dbg_sel),
    .dbg_val(dbg_val),
`endif
    .src_a  (d_src_a),
    .src_b  (d_src_b),
    .dst_e  (W_dst_e),
    .val_e  (W_val_e),
    .dst_m  (W_dst_m),
    .val_m  (W_val_m),
    .rd_a   (rd_a),
    .rd_b   (rd_b)
  );
  always_comb begin
    e_d = E_BUBBLE;
    if (!E_bub) begin
      e_d.icode = D_in_code;
      e_d.ifun  = D_in_fun;
      e_d.stat  = D_stat;
      e_d.val_c = D_val_c;
      e_d.val_a = (D_in_code inside {I_JXX, I_CALL}) ? D_val_p : fwd(d_src_a, rd_a);
      e_d.val_b = fwd(d_src_b, rd_b);
      e_d.dst_e = dst_e;
      e_d.dst_m = dst_m;
      e_d.src_a = d_src_a;
      e_d.src_b = d_src_b;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) e_q <= E_BUBBLE;
    else e_q <= e_d;
  end
  assign E_in_code = e_q.icode;
  assign E_in_fun  = e_q.ifun;
  assign E_stat    = e_q.stat;
  assign E_val_c   = e_q.val_c;
  assign E_val_a   = e_q.val_a;
  assign E_val_b   = e_q.val_b;
  assign E_dst_e   = e_q.dst_e;
  assign E_dst_m   = e_q.dst_m;
  assign E_src_a   = e_q.src_a;
  assign E_src_b   = e_q.src_b;
endmodule
